// File: rtl/chunk_unpacker_if.sv
// rtl/chunk_unpacker_if.sv - packed-word input and chunk output handshake bundle for chunk_unpacker
interface chunk_unpacker_if #(
  parameter int CHUNKS = 5
);
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [11*CHUNKS-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [10:0]           out_data;
  logic [IW-1:0]         out_index;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/chunk_unpacker.sv
// rtl/chunk_unpacker.sv - splits a packed word into 11-bit chunks, MS chunk first (optional CHUNK_UNPACKER_COUNT_EN adds frame_count)
module chunk_unpacker #(
  parameter int CHUNKS = 5
) (
  input  logic            clock,
  input  logic            reset,
  chunk_unpacker_if.slave bus
`ifdef CHUNK_UNPACKER_COUNT_EN
  ,
  output logic [15:0]     frame_count
`endif
);

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int DW = 11 * CHUNKS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_word;
  logic [IW-1:0]   r_idx;

  logic            w_last;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_in_hs;
  logic            w_out_hs;

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; a new word is only taken when idle or
  // while the final chunk of the held word leaves, giving zero-bubble streaming
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_last      = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_out_valid = 1'b1;
        w_last      = (r_idx == IW'(CHUNKS - 1));
        w_in_ready  = w_last && bus.out_ready;
        if (w_last && bus.out_ready) begin
          w_state_nxt = bus.in_valid ? ST_SEND : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_in_hs  = bus.in_valid && w_in_ready;
  assign w_out_hs = w_out_valid && bus.out_ready;

  // Word holder: the current chunk always sits in the top 11 bits, so each
  // accepted chunk shifts the word left by one chunk and bumps the index
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (w_in_hs) begin
      r_word <= bus.in_data;
      r_idx  <= '0;
    end else if (w_out_hs) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_word <= r_word << 11;
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_word[DW-1 -: 11];
  assign bus.out_index = r_idx;
  assign bus.out_last  = w_last;

`ifdef CHUNK_UNPACKER_COUNT_EN
  logic [15:0] r_frame_count;

  // Completed-word counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_out_hs && w_last && (r_frame_count != 16'hFFFF)) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_chunk_unpacker.sv
// tb/tb_chunk_unpacker.sv - scoreboard bench for chunk_unpacker at CHUNKS = 5, 3 and 1
module tb_chunk_unpacker;

  logic clk;
  logic rst5;
  logic rst3;
  logic rst1;
  int   total = 0;
  int   bad   = 0;

  // expected entry: {last, index[3:0], data[10:0]}
  logic [15:0] q5[$];
  logic [15:0] q3[$];
  logic [15:0] q1[$];

  chunk_unpacker_if #(.CHUNKS(5)) in5();
  chunk_unpacker_if #(.CHUNKS(3)) in3();
  chunk_unpacker_if #(.CHUNKS(1)) in1();

`ifdef CHUNK_UNPACKER_COUNT_EN
  logic [15:0] fc5;
  logic [15:0] fc3;
  logic [15:0] fc1;
`endif

  chunk_unpacker #(.CHUNKS(5)) u5 (
    .clock(clk),
    .reset(rst5),
    .bus(in5)
`ifdef CHUNK_UNPACKER_COUNT_EN
    ,
    .frame_count(fc5)
`endif
  );

  chunk_unpacker #(.CHUNKS(3)) u3 (
    .clock(clk),
    .reset(rst3),
    .bus(in3)
`ifdef CHUNK_UNPACKER_COUNT_EN
    ,
    .frame_count(fc3)
`endif
  );

  chunk_unpacker #(.CHUNKS(1)) u1 (
    .clock(clk),
    .reset(rst1),
    .bus(in1)
`ifdef CHUNK_UNPACKER_COUNT_EN
    ,
    .frame_count(fc1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_word(input int which, input logic [54:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] e;
      e = {(k == n - 1) ? 1'b1 : 1'b0, 4'(k), w[11*(n-1-k) +: 11]};
      case (which)
        5:       q5.push_back(e);
        3:       q3.push_back(e);
        default: q1.push_back(e);
      endcase
    end
  endtask

  task automatic put(input int which, input logic [54:0] w);
    int   t;
    logic hs;
    t  = 0;
    hs = 1'b0;
    case (which)
      5:       begin in5.in_valid = 1'b1; in5.in_data = w;        end
      3:       begin in3.in_valid = 1'b1; in3.in_data = w[32:0];  end
      default: begin in1.in_valid = 1'b1; in1.in_data = w[10:0];  end
    endcase
    while (!hs && t < 100) begin
      @(negedge clk);
      case (which)
        5:       hs = in5.in_ready;
        3:       hs = in3.in_ready;
        default: hs = in1.in_ready;
      endcase
      @(posedge clk);
      #1;
      t++;
    end
    total++;
    if (!hs) begin
      bad++;
      $display("FAIL accept%0d: in_ready=0 for 100 cycles, required 1", which);
    end
    case (which)
      5:       in5.in_valid = 1'b0;
      3:       in3.in_valid = 1'b0;
      default: in1.in_valid = 1'b0;
    endcase
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q5.size() + q3.size() + q1.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", q5.size() + q3.size() + q1.size(), 0);
  endtask

  task automatic monitor();
    logic [15:0] e;
    logic [16:0] prev3;
    logic        stall3;
    stall3 = 1'b0;
    prev3  = '0;
    forever begin
      @(negedge clk);
      if (in5.out_valid && in5.out_ready) begin
        if (q5.size() == 0) begin
          total++; bad++;
          $display("FAIL extra5: got chunk %0h idx %0d, required none", in5.out_data, in5.out_index);
        end else begin
          e = q5.pop_front();
          chk("chunk5", {in5.out_last, 4'(in5.out_index), in5.out_data}, e);
        end
      end
      if (in3.out_valid && in3.out_ready) begin
        if (q3.size() == 0) begin
          total++; bad++;
          $display("FAIL extra3: got chunk %0h idx %0d, required none", in3.out_data, in3.out_index);
        end else begin
          e = q3.pop_front();
          chk("chunk3", {in3.out_last, 4'(in3.out_index), in3.out_data}, e);
        end
      end
      if (in1.out_valid && in1.out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL extra1: got chunk %0h idx %0d, required none", in1.out_data, in1.out_index);
        end else begin
          e = q1.pop_front();
          chk("chunk1", {in1.out_last, 4'(in1.out_index), in1.out_data}, e);
        end
      end
      if (stall3) begin
        chk("hold3", {in3.out_valid, in3.out_last, 4'(in3.out_index), in3.out_data}, prev3);
      end
      stall3 = in3.out_valid && !in3.out_ready;
      prev3  = {in3.out_valid, in3.out_last, 4'(in3.out_index), in3.out_data};
    end
  endtask

  initial begin
    logic [54:0] w;
    logic [54:0] a;
    logic [54:0] b;
    rst5 = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
    in5.in_valid = 1'b0; in5.in_data = '0; in5.out_ready = 1'b1;
    in3.in_valid = 1'b0; in3.in_data = '0; in3.out_ready = 1'b1;
    in1.in_valid = 1'b0; in1.in_data = '0; in1.out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst5 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;

    // reset state: {in_ready, out_valid, out_last, index, data}
    @(negedge clk);
    chk("rst5", {in5.in_ready, in5.out_valid, in5.out_last, 4'(in5.out_index), in5.out_data}, {1'b1, 17'h0});
    chk("rst3", {in3.in_ready, in3.out_valid, in3.out_last, 4'(in3.out_index), in3.out_data}, {1'b1, 17'h0});
    chk("rst1", {in1.in_ready, in1.out_valid, in1.out_last, 4'(in1.out_index), in1.out_data}, {1'b1, 17'h0});
`ifdef CHUNK_UNPACKER_COUNT_EN
    chk("fc_rst", fc5, 0);
`endif
    @(posedge clk);
    #1;

    // five chunks, top one 001, on five consecutive cycles
    w = {11'h001, 44'h0};
    push_word(5, w, 5);
    put(5, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq5_valid", in5.out_valid, 1);
      chk("seq5_last", in5.out_last, (i == 4) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("seq5_idle", in5.out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();

    // toggling out_ready: chunks must hold while stalled
    w = {22'h0, 11'h7FF, 11'h155, 11'h2AA};
    push_word(3, w, 3);
    put(3, w);
    for (int i = 0; i < 10; i++) begin
      in3.out_ready = i[0];
      @(posedge clk);
      #1;
    end
    in3.out_ready = 1'b1;
    wait_drain();

    // back-to-back words with in_valid held high
    a = {22'h0, 11'h123, 11'h456, 11'h789};
    b = {22'h0, 11'h0AB, 11'h0CD, 11'h0EF};
    push_word(3, a, 3);
    push_word(3, b, 3);
    in3.in_valid = 1'b1;
    in3.in_data  = a[32:0];
    @(negedge clk);
    chk("b2b_first_ready", in3.in_ready, 1);
    @(posedge clk);
    #1;
    in3.in_data = b[32:0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_in_ready", in3.in_ready, (i == 2 || i == 5) ? 1 : 0);
      chk("b2b_out_valid", in3.out_valid, 1);
      @(posedge clk);
      #1;
      if (i == 2) in3.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", in3.out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain();

    // single-chunk words
    w = {44'h0, 11'h003};
    push_word(1, w, 1);
    put(1, w);
    w = {44'h0, 11'h004};
    push_word(1, w, 1);
    put(1, w);
    wait_drain();

    // reset after the second chunk handshake drops the rest of the word
    q5.push_back({1'b0, 4'd0, 11'h011});
    q5.push_back({1'b0, 4'd1, 11'h022});
    w = {11'h011, 11'h022, 11'h033, 11'h044, 11'h055};
    put(5, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst5 = 1'b1;
    in5.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst5 = 1'b0;
    @(negedge clk);
    chk("rst_mid", {in5.in_ready, in5.out_valid, in5.out_last, 4'(in5.out_index), in5.out_data}, {1'b1, 17'h0});
    @(posedge clk);
    #1;
    in5.out_ready = 1'b1;
    w = {11'h066, 11'h077, 11'h088, 11'h099, 11'h0AA};
    push_word(5, w, 5);
    put(5, w);
    wait_drain();

`ifdef CHUNK_UNPACKER_COUNT_EN
    chk("fc5_after_reset", fc5, 1);
    chk("fc3_three_words", fc3, 3);
    chk("fc1_two_words", fc1, 2);
    in1.in_valid = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      in1.in_data = 11'(i);
      q1.push_back({1'b1, 4'd0, 11'(i)});
      @(posedge clk);
      #1;
    end
    in1.in_valid = 1'b0;
    wait_drain();
    chk("fc1_max", fc1, 16'hFFFF);
    w = {44'h0, 11'h5A5};
    push_word(1, w, 1);
    put(1, w);
    wait_drain();
    chk("fc1_sat", fc1, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
